// File: rtl/fwd_unit_n_pkg.sv
// Shared pipeline constants for the EX-stage operand forwarding unit:
// forward-source select encoding and the hard-wired zero register.
package fwd_unit_n_pkg;

    localparam logic [1:0] FWD_ID   = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;
    localparam logic [1:0] FWD_HIST = 2'd3;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_select_n.sv
// Combinational priority selector for one source operand:
// MEM, then WB, then writeback history (newest first), then register-file data.
module fwd_select_n
    import fwd_unit_n_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int NREG_BITS  = 5,
    parameter int HIST_DEPTH = 2
) (
    input  logic [NREG_BITS-1:0]            rs_addr,
    input  logic [NBITS-1:0]                rs_data,
    input  logic                            mem_wr_en,
    input  logic                            mem_is_load,
    input  logic [NREG_BITS-1:0]            mem_rd,
    input  logic [NBITS-1:0]                mem_data,
    input  logic                            wb_wr_en,
    input  logic [NREG_BITS-1:0]            wb_rd,
    input  logic [NBITS-1:0]                wb_data,
    input  logic [HIST_DEPTH-1:0]           hist_valid,
    input  logic [HIST_DEPTH*NREG_BITS-1:0] hist_rd,
    input  logic [HIST_DEPTH*NBITS-1:0]     hist_data,
    output logic [NBITS-1:0]                fwd_data,
    output logic [1:0]                      fwd_sel,
    output logic                            load_hazard
);

    logic             rs_nonzero;
    logic             mem_match;
    logic             wb_hit;
    logic             hist_hit;
    logic [NBITS-1:0] hist_word;

    assign rs_nonzero  = (rs_addr != NREG_BITS'(REG_ZERO));
    assign mem_match   = rs_nonzero && mem_wr_en && (mem_rd == rs_addr);
    assign load_hazard = mem_match && mem_is_load;
    assign wb_hit      = rs_nonzero && wb_wr_en && (wb_rd == rs_addr);

    // Walk oldest to newest so the newest matching entry overrides older copies.
    always_comb begin
        hist_hit  = 1'b0;
        hist_word = '0;
        for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            if (rs_nonzero && hist_valid[i] && (hist_rd[i*NREG_BITS +: NREG_BITS] == rs_addr)) begin
                hist_hit  = 1'b1;
                hist_word = hist_data[i*NBITS +: NBITS];
            end
        end
    end

    // A pending load blocks fall-through to older sources; the stall covers it.
    always_comb begin
        fwd_data = rs_data;
        fwd_sel  = FWD_ID;
        if (mem_match) begin
            if (!mem_is_load) begin
                fwd_data = mem_data;
                fwd_sel  = FWD_MEM;
            end
        end else if (wb_hit) begin
            fwd_data = wb_data;
            fwd_sel  = FWD_WB;
        end else if (hist_hit) begin
            fwd_data = hist_word;
            fwd_sel  = FWD_HIST;
        end
    end

endmodule

// File: rtl/fwd_unit_n.sv
// EX-stage operand forwarding unit: per-operand selectors, retired-writeback
// history, load-use stall and a single valid/ready output register.
module fwd_unit_n
    import fwd_unit_n_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int NREG_BITS  = 5,
    parameter int NOPS       = 2,
    parameter int HIST_DEPTH = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_id_valid,
    output logic                      o_id_ready,
    input  logic [NOPS*NREG_BITS-1:0] i_rs_addr,
    input  logic [NOPS*NBITS-1:0]     i_rs_data,
    input  logic                      i_mem_wr_en,
    input  logic                      i_mem_is_load,
    input  logic [NREG_BITS-1:0]      i_mem_rd,
    input  logic [NBITS-1:0]          i_mem_data,
    input  logic                      i_wb_wr_en,
    input  logic [NREG_BITS-1:0]      i_wb_rd,
    input  logic [NBITS-1:0]          i_wb_data,
    output logic                      o_op_valid,
    input  logic                      i_ex_ready,
    output logic [NOPS*NBITS-1:0]     o_op_data,
    output logic [NOPS*2-1:0]         o_fwd_sel,
    output logic                      o_load_stall
);

    logic [HIST_DEPTH-1:0]           hist_valid_reg;
    logic [HIST_DEPTH*NREG_BITS-1:0] hist_rd_reg;
    logic [HIST_DEPTH*NBITS-1:0]     hist_data_reg;
    logic                            hist_push;

    logic [NOPS-1:0]                 hazard_vec;
    logic [NOPS*NBITS-1:0]           sel_data;
    logic [NOPS*2-1:0]               sel_code;

    logic                            op_valid_reg;
    logic [NOPS*NBITS-1:0]           op_data_reg;
    logic [NOPS*2-1:0]               fwd_sel_reg;
    logic                            capture;

    genvar gi;
    generate
        for (gi = 0; gi < NOPS; gi++) begin : g_sel
            fwd_select_n #(
                .NBITS      (NBITS),
                .NREG_BITS  (NREG_BITS),
                .HIST_DEPTH (HIST_DEPTH)
            ) u_sel (
                .rs_addr     (i_rs_addr[gi*NREG_BITS +: NREG_BITS]),
                .rs_data     (i_rs_data[gi*NBITS +: NBITS]),
                .mem_wr_en   (i_mem_wr_en),
                .mem_is_load (i_mem_is_load),
                .mem_rd      (i_mem_rd),
                .mem_data    (i_mem_data),
                .wb_wr_en    (i_wb_wr_en),
                .wb_rd       (i_wb_rd),
                .wb_data     (i_wb_data),
                .hist_valid  (hist_valid_reg),
                .hist_rd     (hist_rd_reg),
                .hist_data   (hist_data_reg),
                .fwd_data    (sel_data[gi*NBITS +: NBITS]),
                .fwd_sel     (sel_code[gi*2 +: 2]),
                .load_hazard (hazard_vec[gi])
            );
        end
    endgenerate

    assign o_load_stall = i_id_valid && (|hazard_vec);
    assign o_id_ready   = !o_load_stall && (!op_valid_reg || i_ex_ready);
    assign capture      = i_id_valid && o_id_ready;
    assign hist_push    = i_wb_wr_en && (i_wb_rd != NREG_BITS'(REG_ZERO));

    // Entry 0 is the newest; older entries shift up on every qualifying WB write.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hist_valid_reg[0]         <= 1'b0;
            hist_rd_reg[0 +: NREG_BITS] <= '0;
            hist_data_reg[0 +: NBITS] <= '0;
        end else if (hist_push) begin
            hist_valid_reg[0]         <= 1'b1;
            hist_rd_reg[0 +: NREG_BITS] <= i_wb_rd;
            hist_data_reg[0 +: NBITS] <= i_wb_data;
        end
    end

    generate
        for (gi = 1; gi < HIST_DEPTH; gi++) begin : g_hist
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    hist_valid_reg[gi]                  <= 1'b0;
                    hist_rd_reg[gi*NREG_BITS +: NREG_BITS] <= '0;
                    hist_data_reg[gi*NBITS +: NBITS]    <= '0;
                end else if (hist_push) begin
                    hist_valid_reg[gi]                  <= hist_valid_reg[gi-1];
                    hist_rd_reg[gi*NREG_BITS +: NREG_BITS] <= hist_rd_reg[(gi-1)*NREG_BITS +: NREG_BITS];
                    hist_data_reg[gi*NBITS +: NBITS]    <= hist_data_reg[(gi-1)*NBITS +: NBITS];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            op_valid_reg <= 1'b0;
            op_data_reg  <= '0;
            fwd_sel_reg  <= '0;
        end else if (capture) begin
            op_valid_reg <= 1'b1;
            op_data_reg  <= sel_data;
            fwd_sel_reg  <= sel_code;
        end else if (i_ex_ready) begin
            op_valid_reg <= 1'b0;
        end
    end

    assign o_op_valid = op_valid_reg;
    assign o_op_data  = op_data_reg;
    assign o_fwd_sel  = fwd_sel_reg;

endmodule

// File: tb/tb_fwd_unit_n.sv
// Scoreboard bench for fwd_unit_n: expected operand words are queued when an
// instruction is accepted and compared when the output register presents them.
module tb_fwd_unit_n;

    localparam int NBITS = 32;
    localparam int NRB   = 5;
    localparam int NOPS  = 2;
    localparam int HD    = 2;

    logic                   i_clk = 1'b0;
    logic                   i_reset_n;
    logic                   i_id_valid;
    logic                   o_id_ready;
    logic [NOPS*NRB-1:0]    i_rs_addr;
    logic [NOPS*NBITS-1:0]  i_rs_data;
    logic                   i_mem_wr_en;
    logic                   i_mem_is_load;
    logic [NRB-1:0]         i_mem_rd;
    logic [NBITS-1:0]       i_mem_data;
    logic                   i_wb_wr_en;
    logic [NRB-1:0]         i_wb_rd;
    logic [NBITS-1:0]       i_wb_data;
    logic                   o_op_valid;
    logic                   i_ex_ready;
    logic [NOPS*NBITS-1:0]  o_op_data;
    logic [NOPS*2-1:0]      o_fwd_sel;
    logic                   o_load_stall;

    typedef struct {
        logic [NOPS*NBITS-1:0] data;
        logic [NOPS*2-1:0]     sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;

    always #5 i_clk = ~i_clk;

    fwd_unit_n #(.NBITS(NBITS), .NREG_BITS(NRB), .NOPS(NOPS), .HIST_DEPTH(HD)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_id_valid    (i_id_valid),
        .o_id_ready    (o_id_ready),
        .i_rs_addr     (i_rs_addr),
        .i_rs_data     (i_rs_data),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_is_load (i_mem_is_load),
        .i_mem_rd      (i_mem_rd),
        .i_mem_data    (i_mem_data),
        .i_wb_wr_en    (i_wb_wr_en),
        .i_wb_rd       (i_wb_rd),
        .i_wb_data     (i_wb_data),
        .o_op_valid    (o_op_valid),
        .i_ex_ready    (i_ex_ready),
        .o_op_data     (o_op_data),
        .o_fwd_sel     (o_fwd_sel),
        .o_load_stall  (o_load_stall)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_id_valid    = 1'b0;
        i_rs_addr     = '0;
        i_rs_data     = '0;
        i_mem_wr_en   = 1'b0;
        i_mem_is_load = 1'b0;
        i_mem_rd      = '0;
        i_mem_data    = '0;
        i_wb_wr_en    = 1'b0;
        i_wb_rd       = '0;
        i_wb_data     = '0;
        i_ex_ready    = 1'b1;
    endtask

    task automatic set_id(input logic [NRB-1:0] rs0, input logic [NBITS-1:0] d0,
                          input logic [NRB-1:0] rs1, input logic [NBITS-1:0] d1);
        i_id_valid = 1'b1;
        i_rs_addr  = {rs1, rs0};
        i_rs_data  = {d1, d0};
    endtask

    task automatic set_wb(input logic en, input logic [NRB-1:0] rd, input logic [NBITS-1:0] d);
        i_wb_wr_en = en;
        i_wb_rd    = rd;
        i_wb_data  = d;
    endtask

    task automatic set_mem(input logic en, input logic ld, input logic [NRB-1:0] rd, input logic [NBITS-1:0] d);
        i_mem_wr_en   = en;
        i_mem_is_load = ld;
        i_mem_rd      = rd;
        i_mem_data    = d;
    endtask

    task automatic push_exp(input logic [NOPS*NBITS-1:0] d, input logic [NOPS*2-1:0] s);
        exp_t e;
        e.data = d;
        e.sel  = s;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        idle_inputs();
        i_reset_n = 1'b0;
        exp_q.delete();
        tick();
        tick();
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (o_op_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_op_valid); end
        checks++; if (o_op_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_op_data); end
        checks++; if (o_fwd_sel !== '0) begin errors++; $display("FAIL reset_sel got=%h exp=0", o_fwd_sel); end
        checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_id_ready); end
        $display("test_reset done");
    endtask

    task automatic test_id_path();
        idle_inputs();
        set_id(5'd3, 32'h11, 5'd0, 32'h22);
        push_exp({32'h22, 32'h11}, 4'b0000);
        tick();
        idle_inputs();
        got = exp_q.pop_front();
        checks++; if (o_op_valid !== 1'b1) begin errors++; $display("FAIL id_valid got=%0b exp=1", o_op_valid); end
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL id_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL id_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("id path: data=%h sel=%h", o_op_data, o_fwd_sel);
    endtask

    task automatic test_mem_wb();
        idle_inputs();
        set_id(5'd3, 32'h11, 5'd4, 32'h99);
        set_mem(1'b1, 1'b0, 5'd4, 32'hAA);
        set_wb(1'b1, 5'd4, 32'hBB);
        push_exp({32'hAA, 32'h11}, 4'b0100);
        tick();
        got = exp_q.pop_front();
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL mem_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL mem_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("mem priority: data=%h sel=%h", o_op_data, o_fwd_sel);
        set_mem(1'b1, 1'b0, 5'd0, 32'hAA);
        push_exp({32'hBB, 32'h11}, 4'b1000);
        tick();
        idle_inputs();
        got = exp_q.pop_front();
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL wb_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL wb_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("wb when mem rd=r0: data=%h sel=%h", o_op_data, o_fwd_sel);
    endtask

    task automatic test_history();
        apply_reset();
        set_wb(1'b1, 5'd7, 32'h55);
        tick();
        idle_inputs();
        tick();
        tick();
        set_id(5'd7, 32'h01, 5'd0, 32'h02);
        push_exp({32'h02, 32'h55}, 4'b0011);
        tick();
        idle_inputs();
        got = exp_q.pop_front();
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL hist_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL hist_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("history hit: data=%h sel=%h", o_op_data, o_fwd_sel);
        set_wb(1'b1, 5'd10, 32'hA0);
        tick();
        set_wb(1'b1, 5'd11, 32'hB0);
        tick();
        idle_inputs();
        tick();
        set_id(5'd7, 32'h01, 5'd0, 32'h02);
        push_exp({32'h02, 32'h01}, 4'b0000);
        tick();
        idle_inputs();
        got = exp_q.pop_front();
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL evict_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL evict_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("history evicted: data=%h sel=%h", o_op_data, o_fwd_sel);
        set_wb(1'b1, 5'd5, 32'h10);
        tick();
        set_wb(1'b1, 5'd5, 32'h20);
        tick();
        idle_inputs();
        tick();
        set_id(5'd0, 32'h03, 5'd5, 32'h04);
        push_exp({32'h20, 32'h03}, 4'b1100);
        tick();
        idle_inputs();
        got = exp_q.pop_front();
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL newest_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL newest_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("newest duplicate wins: data=%h sel=%h", o_op_data, o_fwd_sel);
    endtask

    task automatic test_load_stall();
        idle_inputs();
        set_id(5'd3, 32'h11, 5'd0, 32'h22);
        push_exp({32'h22, 32'h11}, 4'b0000);
        tick();
        got = exp_q.pop_front();
        checks++; if (o_op_valid !== 1'b1) begin errors++; $display("FAIL pre_stall_valid got=%0b exp=1", o_op_valid); end
        set_id(5'd3, 32'h11, 5'd9, 32'hEE);
        set_mem(1'b1, 1'b1, 5'd9, 32'hCC);
        #1;
        checks++; if (o_load_stall !== 1'b1) begin errors++; $display("FAIL stall_flag got=%0b exp=1", o_load_stall); end
        checks++; if (o_id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%0b exp=0", o_id_ready); end
        tick();
        checks++; if (o_op_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got=%0b exp=0", o_op_valid); end
        $display("load-use stall: stall=%0b valid=%0b", o_load_stall, o_op_valid);
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 5'd9, 32'h77);
        #1;
        checks++; if (o_load_stall !== 1'b0) begin errors++; $display("FAIL unstall_flag got=%0b exp=0", o_load_stall); end
        push_exp({32'h77, 32'h11}, 4'b1000);
        tick();
        got = exp_q.pop_front();
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL ldwb_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL ldwb_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("load resolved via wb: data=%h sel=%h", o_op_data, o_fwd_sel);
        // r9 now sits in history; a new load to r9 must still stall.
        set_wb(1'b0, 5'd0, 32'h0);
        set_mem(1'b1, 1'b1, 5'd9, 32'hCC);
        #1;
        checks++; if (o_load_stall !== 1'b1) begin errors++; $display("FAIL stall_over_hist got=%0b exp=1", o_load_stall); end
        $display("load over history: stall=%0b", o_load_stall);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_ex_stall();
        exp_t held;
        idle_inputs();
        set_id(5'd3, 32'h11, 5'd0, 32'h22);
        push_exp({32'h22, 32'h11}, 4'b0000);
        tick();
        held = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            i_ex_ready = 1'b0;
            set_id(5'd3, 32'h40 + i, 5'd0, 32'h22);
            set_wb(1'b1, 5'd3, 32'h60 + i);
            set_mem(1'b1, 1'b0, 5'd3, 32'h70 + i);
            #1;
            checks++; if (o_id_ready !== 1'b0) begin errors++; $display("FAIL exstall_ready%0d got=%0b exp=0", i, o_id_ready); end
            checks++; if (o_op_data !== held.data) begin errors++; $display("FAIL exstall_data%0d got=%h exp=%h", i, o_op_data, held.data); end
            checks++; if (o_fwd_sel !== held.sel) begin errors++; $display("FAIL exstall_sel%0d got=%h exp=%h", i, o_fwd_sel, held.sel); end
            tick();
        end
        $display("ex stall held: data=%h sel=%h", o_op_data, o_fwd_sel);
        i_ex_ready = 1'b1;
        set_mem(1'b0, 1'b0, 5'd0, 32'h0);
        set_id(5'd3, 32'h12, 5'd0, 32'h22);
        set_wb(1'b1, 5'd3, 32'h66);
        #1;
        checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%0b exp=1", o_id_ready); end
        push_exp({32'h22, 32'h66}, 4'b0010);
        tick();
        idle_inputs();
        got = exp_q.pop_front();
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL release_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL release_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("after release: data=%h sel=%h", o_op_data, o_fwd_sel);
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        set_wb(1'b1, 5'd7, 32'h55);
        tick();
        idle_inputs();
        set_id(5'd3, 32'h11, 5'd0, 32'h22);
        push_exp({32'h22, 32'h11}, 4'b0000);
        tick();
        got = exp_q.pop_front();
        i_ex_ready = 1'b0;
        set_id(5'd3, 32'h11, 5'd9, 32'hEE);
        set_mem(1'b1, 1'b1, 5'd9, 32'hCC);
        tick();
        #1;
        i_reset_n = 1'b0;
        #1;
        checks++; if (o_op_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", o_op_valid); end
        checks++; if (o_op_data !== '0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", o_op_data); end
        checks++; if (o_fwd_sel !== '0) begin errors++; $display("FAIL rst_mid_sel got=%h exp=0", o_fwd_sel); end
        checks++; if (o_load_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall got=%0b exp=1", o_load_stall); end
        $display("reset mid-stall: valid=%0b data=%h stall=%0b", o_op_valid, o_op_data, o_load_stall);
        #2;
        i_reset_n = 1'b1;
        tick();
        idle_inputs();
        set_id(5'd7, 32'h33, 5'd0, 32'h44);
        push_exp({32'h44, 32'h33}, 4'b0000);
        tick();
        idle_inputs();
        got = exp_q.pop_front();
        checks++; if (o_op_data !== got.data) begin errors++; $display("FAIL post_rst_data got=%h exp=%h", o_op_data, got.data); end
        checks++; if (o_fwd_sel !== got.sel) begin errors++; $display("FAIL post_rst_sel got=%h exp=%h", o_fwd_sel, got.sel); end
        $display("post reset r7 from ID: data=%h sel=%h", o_op_data, o_fwd_sel);
    endtask

    initial begin
        i_reset_n = 1'b1;
        idle_inputs();
        test_reset();
        test_id_path();
        test_mem_wb();
        test_history();
        test_load_stall();
        test_ex_stall();
        test_reset_mid_stall();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
